mul_seq: RTL and testbench

- Sequential shift-add unsigned multiplier.
- Operand-side companion of the cube-root unit: the cube-root datapath issues its trial products (y*y, 3*y*(y+1) terms) through it.
- Shares the start_i/busy_o handshake of the arithmetic units, so it can also be benched standalone.
- Produces one 2*WIDTH-bit product per request, one partial-product bit per clock.

---
 rtl/mul_seq.sv | 103 ++++++++++
 tb/tb_mul_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-add unsigned multiplier, one partial product per clock
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_bi,
    input  logic [WIDTH-1:0]     b_bi,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   y_bo
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_K = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    // Partial product for the current iteration, zero-extended before the shift
    // so that no bit of a_q << k is lost.
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   part;
    logic [PW-1:0]   acc_sum;

    assign a_ext   = {{WIDTH{1'b0}}, a_q};
    assign part    = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    assign acc_sum = acc_q + part;

    // State and datapath registers; reset clears every register immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: accept a request in IDLE, accumulate one bit per WORK edge,
    // publish the product on the edge that handles the top multiplier bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_bi;
                    b_d     = b_bi;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = WORK;
                end
            end
            WORK: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_K) begin
                    y_d     = acc_sum;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == WORK);
    assign done_o = done_q;
    assign y_bo   = y_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq with vector table and product scoreboard
module tb_mul_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] y;
    } vec_t;

    logic           clk_i;
    logic           rst_i;
    logic           start_i;
    logic [W-1:0]   a_bi;
    logic [W-1:0]   b_bi;
    logic           busy_o;
    logic           done_o;
    logic [2*W-1:0] y_bo;

    int tests;
    int fails;
    int cyc;
    logic [2*W-1:0] sb_q[$];
    logic [2*W-1:0] sb_exp;
    vec_t vecs[7];

    mul_seq #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .y_bo    (y_bo)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expected product.
    always @(negedge clk_i) begin
        if (rst_i && done_o) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done with y=%0d expected no done", y_bo);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_product", 32'(y_bo), 32'(sb_exp));
            end
        end
    end

    // One operation with a one-cycle start pulse; operands are scrambled after the start edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int n;
        logic stable;
        logic [2*W-1:0] prev_y;
        @(negedge clk_i);
        prev_y  = y_bo;
        a_bi    = a;
        b_bi    = b;
        start_i = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk_i);
        start_i = 1'b0;
        a_bi    = 8'($urandom);
        b_bi    = 8'($urandom);
        n       = 0;
        stable  = 1'b1;
        while (busy_o && n < 64) begin
            n++;
            if (y_bo !== prev_y) stable = 1'b0;
            @(negedge clk_i);
        end
        check("busy_len", 32'(n), 32'(W));
        check("y_hold_during_work", 32'(stable), 32'd1);
        check("done_pulse", 32'(done_o), 32'd1);
        check("y_on_done", 32'(y_bo), 32'(exp));
        @(negedge clk_i);
        check("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    initial begin
        int n;
        int last_done;
        logic flag;

        tests   = 0;
        fails   = 0;
        cyc     = 0;
        rst_i   = 1'b0;
        start_i = 1'b0;
        a_bi    = '0;
        b_bi    = '0;

        vecs[0] = '{a: 8'd255, b: 8'd255, y: 16'd65025};
        vecs[1] = '{a: 8'd0,   b: 8'd200, y: 16'd0};
        vecs[2] = '{a: 8'd1,   b: 8'd128, y: 16'd128};
        vecs[3] = '{a: 8'd200, b: 8'd3,   y: 16'd600};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   y: 16'd0};
        vecs[5] = '{a: 8'd128, b: 8'd255, y: 16'd32640};
        vecs[6] = '{a: 8'd37,  b: 8'd1,   y: 16'd37};

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_y", 32'(y_bo), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_busy", 32'(busy_o), 32'd0);

        // 13 * 11 with long hold check
        run_op(8'd13, 8'd11, 16'd143);
        repeat (20) @(negedge clk_i);
        check("y_hold_20", 32'(y_bo), 32'd143);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].y);
        end

        // Start while busy is ignored
        @(negedge clk_i);
        a_bi    = 8'd7;
        b_bi    = 8'd9;
        start_i = 1'b1;
        sb_q.push_back(16'd63);
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (busy_o && n < 64) begin
            n++;
            if (n == 3) begin
                a_bi    = 8'd100;
                b_bi    = 8'd100;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        check("ign_busy_len", 32'(n), 32'(W));
        check("ign_y", 32'(y_bo), 32'd63);
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (busy_o) flag = 1'b1;
        end
        check("ign_no_restart", 32'(flag), 32'd0);

        // start_i held high: back-to-back operations
        @(negedge clk_i);
        a_bi    = 8'd5;
        b_bi    = 8'd6;
        start_i = 1'b1;
        sb_q.push_back(16'd30);
        @(negedge clk_i);
        last_done = 0;
        for (int op = 0; op < 3; op++) begin
            n = 0;
            while (busy_o && n < 64) begin
                n++;
                @(negedge clk_i);
            end
            check("btb_busy_len", 32'(n), 32'(W));
            check("btb_done", 32'(done_o), 32'd1);
            check("btb_y", 32'(y_bo), 32'd30);
            if (op > 0) check("btb_done_period", 32'(cyc - last_done), 32'd9);
            last_done = cyc;
            if (op < 2) sb_q.push_back(16'd30);
            else start_i = 1'b0;
            @(negedge clk_i);
            check("btb_gap", 32'(busy_o), (op < 2) ? 32'd1 : 32'd0);
        end

        // Reset in the middle of an operation
        @(negedge clk_i);
        a_bi    = 8'd200;
        b_bi    = 8'd3;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("mid_busy", 32'(busy_o), 32'd1);
        repeat (4) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_y", 32'(y_bo), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            if (done_o || busy_o) flag = 1'b1;
        end
        check("mid_rst_quiet", 32'(flag), 32'd0);
        run_op(8'd3, 8'd4, 16'd12);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
